spi_mem_loader: RTL
===================

Name: spi_mem_loader

Overview:
- Serial program/data loader for the tiny processor; parametrised successor of the fixed csi/csd/mosi load path.
- While the core is halted (proc_en=0), it shifts MSB-first words from mosi and writes them into instruction memory (csi frame) or data memory (csd frame).
- It adds per-frame auto-increment addressing, back-to-back streaming, abort/error detection and wrap reporting.
- Sits between the uio_in pins and the imem/dmem write ports.

Parameters:
- INSTR_W, 8, instruction word width (bits per csi word)
- DATA_W, 8, data word width (bits per csd word)
- IADDR_W, 4, instruction memory address width
- DADDR_W, 4, data memory address width

Ports:
- clk  in  1  system clock; mosi sampled on rising edge
- rst_n  in  1  reset, synchronous, active-low
- proc_en  in  1  1 = core running, loader ignores inputs
- csi  in  1  instruction frame select, active-high
- csd  in  1  data frame select, active-high
- mosi  in  1  serial data, MSB first, one bit per clk while selected
- imem_we  out  1  one-cycle instruction write strobe
- imem_addr  out  IADDR_W  instruction write address
- imem_wdata  out  INSTR_W  instruction write data
- dmem_we  out  1  one-cycle data write strobe
- dmem_addr  out  DADDR_W  data write address
- dmem_wdata  out  DATA_W  data write data
- busy  out  1  frame in progress or write pending
- err  out  1  sticky error flag
- miso  out  1  readback bit (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; shift reg, bit counter and both address pointers 0.
- States:
  - IDLE: waits for a frame start.
  - SHIFT_I: csi frame.
  - SHIFT_D: csd frame.
  - HOLD: both selects were high; waits until both are low.
- IDLE -> SHIFT_I when proc_en=0, csi=1, csd=0. The mosi bit in that cycle is bit 0 of the frame.
  - Pointer set to 0; err cleared. SHIFT_D is symmetric on csd.
- In SHIFT_x, each cycle the select stays high samples mosi into the shift reg and increments the counter.
  - On the W-th bit (W = INSTR_W or DATA_W), the word is copied to the write register and the counter returns to 0.
  - Next cycle: x_we=1 for exactly one cycle, with addr = pointer and wdata = word. Pointer increments after the write.
  - Latency: last bit sampled at edge N, we high in cycle N+1.
  - Streaming: the next word's bits shift during the write cycle with no gap. Words of unlimited count per frame.
- Address wrap: pointer at 2^ADDR_W-1 increments to 0 and sets err; writing continues (overwrites address 0).
- Select deasserts with counter = 0 -> IDLE, no error. With counter != 0 -> partial word discarded, err=1, -> IDLE.
- A pending write completes even if the select drops in the same cycle.
- csi and csd both high, in any state -> abort, discard partial word, err=1, -> HOLD. HOLD -> IDLE only when csi=csd=0.
- proc_en rises mid-frame -> abort, discard partial word, err=1, -> IDLE. A pending write still completes.
- proc_en=1 in IDLE: selects ignored, no writes, err unchanged.
- imem_we and dmem_we are never high in the same cycle.
- busy = (state != IDLE) or a write is pending.
- err: sticky; cleared only by reset or a valid frame start.
- Reset mid-frame: everything returns to reset values; no write is issued at that edge.

Optional Feature:
- Macro: LOADER_READBACK_EN.
- Defined: miso = registered MSB shifted out of the shift reg, so the host sees the previous word echoed, delayed W bits, for verification. miso=0 in IDLE/HOLD.
- Undefined: miso tied to 0, readback logic absent; all other behaviour identical.

Test Plan:
- Reset, then csi frame of 8 bits 0xA5, then csi low -> imem_we one cycle after the 8th bit; imem_addr=0, imem_wdata=0xA5; err=0, busy then 0.
- csd frame streaming 0x11,0x22,0x33 with no gaps -> three dmem_we pulses 8 cycles apart; addr 0,1,2; data 0x11,0x22,0x33.
- csi frame of 17 words 0x00..0x10 (IADDR_W=4) -> 17th write goes to addr 0 with data 0x10; err=1 from the wrap.
- csd frame dropped after 5 bits -> no dmem_we, err=1; next valid csi frame start clears err to 0.
- csi and csd both high mid-frame -> no write, err=1, loader stays in HOLD until both are low. Also: proc_en=1 with csi frame -> no writes.
- LOADER_READBACK_EN defined: stream 0xC3 then 0x5A -> miso shows 1,1,0,0,0,0,1,1 during the second word's 8 bits.

Source files
------------

// File: rtl/spi_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : spi_mem_loader
// Description : Serial loader that shifts MSB-first words from mosi into the
//               instruction (csi frame) or data (csd frame) memory while the
//               core is halted. Optional readback: define LOADER_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mem_loader #(
  parameter int INSTR_W = 8,
  parameter int DATA_W  = 8,
  parameter int IADDR_W = 4,
  parameter int DADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               proc_en,
  input  logic               csi,
  input  logic               csd,
  input  logic               mosi,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               busy,
  output logic               err,
  output logic               miso
);

  localparam int c_MAX_W = (INSTR_W > DATA_W) ? INSTR_W : DATA_W;
  localparam int c_CNT_W = $clog2(c_MAX_W);
`ifdef LOADER_READBACK_EN
  // Full word kept so its MSB can be echoed while the next word shifts in.
  localparam int c_SH_W  = c_MAX_W;
`else
  localparam int c_SH_W  = c_MAX_W - 1;
`endif

  localparam logic [c_CNT_W-1:0] c_ILAST = c_CNT_W'(INSTR_W - 1);
  localparam logic [c_CNT_W-1:0] c_DLAST = c_CNT_W'(DATA_W - 1);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_SHIFT_I = 2'd1;
  localparam logic [1:0] c_ST_SHIFT_D = 2'd2;
  localparam logic [1:0] c_ST_HOLD    = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_SH_W-1:0]  r_shift;
  logic [c_SH_W:0]    w_shift_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [IADDR_W-1:0] r_iptr;
  logic [DADDR_W-1:0] r_dptr;
  logic [IADDR_W-1:0] w_iptr_cur;
  logic [DADDR_W-1:0] w_dptr_cur;
  logic               r_err;
  logic               w_start;
  logic               w_shift;
  logic               w_word_done;
  logic               w_err_set;
  logic               w_cnt_clr;
  logic               w_sel_instr;

  assign w_shift_nxt = {r_shift, mosi};
  assign w_sel_instr = (r_state == c_ST_SHIFT_I) || ((r_state == c_ST_IDLE) && csi);
  // A frame start rewinds the pointer before its first word can be written.
  assign w_iptr_cur  = w_start ? '0 : r_iptr;
  assign w_dptr_cur  = w_start ? '0 : r_dptr;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_word_done = 1'b0;
    w_err_set   = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (!proc_en) begin
          if (csi && csd) begin
            w_state_nxt = c_ST_HOLD;
            w_err_set   = 1'b1;
          end else if (csi || csd) begin
            w_state_nxt = csi ? c_ST_SHIFT_I : c_ST_SHIFT_D;
            w_start     = 1'b1;
            w_shift     = 1'b1;
            w_word_done = (r_cnt == (csi ? c_ILAST : c_DLAST));
          end
        end
      end
      c_ST_SHIFT_I, c_ST_SHIFT_D: begin
        if (csi && csd) begin
          w_state_nxt = c_ST_HOLD;
          w_err_set   = 1'b1;
          w_cnt_clr   = 1'b1;
        end else if (proc_en) begin
          w_state_nxt = c_ST_IDLE;
          w_err_set   = 1'b1;
          w_cnt_clr   = 1'b1;
        end else if (w_sel_instr ? csi : csd) begin
          w_shift     = 1'b1;
          w_word_done = (r_cnt == (w_sel_instr ? c_ILAST : c_DLAST));
        end else begin
          w_state_nxt = c_ST_IDLE;
          w_err_set   = (r_cnt != '0);
          w_cnt_clr   = 1'b1;
        end
      end
      default: begin
        if (!csi && !csd) w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (r_state != c_ST_IDLE) || imem_we || dmem_we;
    err  = r_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_iptr     <= '0;
      r_dptr     <= '0;
      r_err      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      if (w_shift) r_shift <= w_shift_nxt[c_SH_W-1:0];
      if (w_cnt_clr || w_word_done) r_cnt <= '0;
      else if (w_shift)             r_cnt <= r_cnt + c_CNT_W'(1);
      if (w_start) begin
        r_err <= 1'b0;
        if (w_sel_instr) r_iptr <= '0;
        else             r_dptr <= '0;
      end
      if (w_err_set) r_err <= 1'b1;
      if (w_word_done) begin
        // Pointer wrap is reported but writing carries on from address 0.
        if (w_sel_instr) begin
          imem_we    <= 1'b1;
          imem_addr  <= w_iptr_cur;
          imem_wdata <= w_shift_nxt[INSTR_W-1:0];
          r_iptr     <= w_iptr_cur + IADDR_W'(1);
          if (&w_iptr_cur) r_err <= 1'b1;
        end else begin
          dmem_we    <= 1'b1;
          dmem_addr  <= w_dptr_cur;
          dmem_wdata <= w_shift_nxt[DATA_W-1:0];
          r_dptr     <= w_dptr_cur + DADDR_W'(1);
          if (&w_dptr_cur) r_err <= 1'b1;
        end
      end
    end
  end

`ifdef LOADER_READBACK_EN
  logic r_miso;
  always_ff @(posedge clk) begin
    if (!rst_n)       r_miso <= 1'b0;
    else if (w_shift) r_miso <= w_sel_instr ? r_shift[INSTR_W-1] : r_shift[DATA_W-1];
    else              r_miso <= 1'b0;
  end
  assign miso = r_miso;
`else
  assign miso = 1'b0;
`endif

endmodule
`default_nettype wire
